// File: rtl/lab1_imul_mul_arbiter.sv
// Round-robin arbiter that shares one iterative multiplier between two val/rdy clients.
// Only one transaction is ever in flight; its product is steered back to the client that issued it.
module lab1_imul_mul_arbiter #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [2*p_nbits-1:0]   req0_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [2*p_nbits-1:0]   req1_msg,

  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [p_nbits-1:0]     resp0_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [p_nbits-1:0]     resp1_msg,

  output logic                   mul_req_val,
  input  logic                   mul_req_rdy,
  output logic [2*p_nbits-1:0]   mul_req_msg,
  input  logic                   mul_resp_val,
  output logic                   mul_resp_rdy,
  input  logic [p_nbits-1:0]     mul_resp_msg,

  output logic                   busy,
  output logic                   owner
);

  // state | meaning
  // IDLE  | nothing outstanding; arbitrate and forward the winning request
  // BUSY  | multiplier holds owner_q's operands; route its response back
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   owner_q, owner_d;
  logic   grant_val;
  logic   grant_idx;

  always_comb begin
    grant_val = 1'b0;
    grant_idx = prio_q;
    if (prio_q == 1'b0) begin
      if (req0_val) begin
        grant_val = 1'b1;
        grant_idx = 1'b0;
      end else if (req1_val) begin
        grant_val = 1'b1;
        grant_idx = 1'b1;
      end
    end else begin
      if (req1_val) begin
        grant_val = 1'b1;
        grant_idx = 1'b1;
      end else if (req0_val) begin
        grant_val = 1'b1;
        grant_idx = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    req0_rdy     = 1'b0;
    req1_rdy     = 1'b0;
    mul_req_val  = 1'b0;
    mul_req_msg  = '0;
    mul_resp_rdy = 1'b0;
    resp0_val    = 1'b0;
    resp0_msg    = '0;
    resp1_val    = 1'b0;
    resp1_msg    = '0;
    busy         = 1'b0;

    case (state_q)
      IDLE: begin
        mul_req_val = grant_val;
        if (grant_val) begin
          mul_req_msg = grant_idx ? req1_msg : req0_msg;
        end
        req0_rdy = mul_req_rdy && grant_val && !grant_idx;
        req1_rdy = mul_req_rdy && grant_val && grant_idx;
        if (mul_req_val && mul_req_rdy) begin
          owner_d = grant_idx;
          prio_d  = ~grant_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (owner_q) begin
          resp1_val    = mul_resp_val;
          resp1_msg    = mul_resp_msg;
          mul_resp_rdy = resp1_rdy;
        end else begin
          resp0_val    = mul_resp_val;
          resp0_msg    = mul_resp_msg;
          mul_resp_rdy = resp0_rdy;
        end
        if (mul_resp_val && mul_resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshakes stay quiet for as long as reset is held, independent of client inputs.
    if (reset) begin
      req0_rdy     = 1'b0;
      req1_rdy     = 1'b0;
      mul_req_val  = 1'b0;
      mul_resp_rdy = 1'b0;
      resp0_val    = 1'b0;
      resp1_val    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  assign owner = owner_q;

  // A multiplier response with no outstanding transaction would be silently lost.
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (reset)
    !(state_q == IDLE && mul_resp_val));

endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// Bench for the multiplier arbiter: behavioural multiplier, queued requesters, scoreboard monitor.
module tb_lab1_imul_mul_arbiter;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  logic req0_val, req1_val;
  logic [2*N-1:0] req0_msg, req1_msg;
  logic req0_rdy, req1_rdy;
  logic resp0_val, resp1_val;
  logic resp0_rdy, resp1_rdy;
  logic [N-1:0] resp0_msg, resp1_msg;
  logic mul_req_val, mul_req_rdy;
  logic [2*N-1:0] mul_req_msg;
  logic mul_resp_val, mul_resp_rdy;
  logic [N-1:0] mul_resp_msg;
  logic busy, owner;

  logic mrdy_en;
  logic m_busy;
  int m_cnt;
  logic [N-1:0] m_a, m_b;

  typedef struct packed {
    logic idx;
    logic [2*N-1:0] msg;
  } gnt_t;

  gnt_t gq[$];
  logic [N-1:0] e0[$], e1[$];
  logic [2*N-1:0] pend0[$], pend1[$];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lab1_imul_mul_arbiter #(.p_nbits(N)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .busy(busy), .owner(owner)
  );

  // Iterative multiplier stand-in: three cycles of latency, holds its result until taken.
  assign mul_req_rdy  = !m_busy && mrdy_en;
  assign mul_resp_val = m_busy && (m_cnt == 0);
  assign mul_resp_msg = m_a * m_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int p, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] prod);
    gnt_t g;
    g.idx = (p != 0);
    g.msg = {a, b};
    gq.push_back(g);
    if (p == 0) begin
      pend0.push_back({a, b});
      e0.push_back(prod);
    end else begin
      pend1.push_back({a, b});
      e1.push_back(prod);
    end
  endtask

  task automatic wait_for(input int sel, input string nm);
    int n = 0;
    logic ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      n++;
      case (sel)
        0: ok = busy;
        1: ok = mul_resp_val;
        default: ok = (gq.size() == 0) && (e0.size() == 0) && (e1.size() == 0) &&
                      (pend0.size() == 0) && (pend1.size() == 0) &&
                      !busy && !req0_val && !req1_val;
      endcase
    end
    chk(nm, {63'b0, ok}, 64'd1);
  endtask

  initial begin : mul_model
    logic rf, pf, rs;
    logic [2*N-1:0] ops;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_a    = '0;
    m_b    = '0;
    forever begin
      @(negedge clk);
      rf  = mul_req_val && mul_req_rdy;
      pf  = mul_resp_val && mul_resp_rdy;
      rs  = reset;
      ops = mul_req_msg;
      @(posedge clk);
      #1;
      if (rs) begin
        m_busy = 1'b0;
      end else if (pf) begin
        m_busy = 1'b0;
      end else if (rf) begin
        m_busy = 1'b1;
        m_a    = ops[2*N-1:N];
        m_b    = ops[N-1:0];
        m_cnt  = 3;
      end else if (m_busy && m_cnt > 0) begin
        m_cnt--;
      end
    end
  end

  initial begin : req_driver
    logic f0, f1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    req0_msg = '0;
    req1_msg = '0;
    forever begin
      @(negedge clk);
      f0 = req0_val && req0_rdy;
      f1 = req1_val && req1_rdy;
      @(posedge clk);
      #1;
      if (f0 || !req0_val) begin
        if (pend0.size() > 0) begin
          req0_msg = pend0.pop_front();
          req0_val = 1'b1;
        end else begin
          req0_val = 1'b0;
        end
      end
      if (f1 || !req1_val) begin
        if (pend1.size() > 0) begin
          req1_msg = pend1.pop_front();
          req1_val = 1'b1;
        end else begin
          req1_val = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    gnt_t g;
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mul_req_val && mul_req_rdy) begin
          if (gq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL mul_req_unexpected: got msg 0x%0h, expected no request", mul_req_msg);
          end else begin
            g = gq.pop_front();
            chk("grant", {62'b0, req1_rdy, req0_rdy}, g.idx ? 64'd2 : 64'd1);
            chk("mul_req_msg", mul_req_msg, g.msg);
          end
        end
        if (resp0_val && resp0_rdy) begin
          if (e0.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL resp0_unexpected: got 0x%0h, expected no response", resp0_msg);
          end else begin
            e = e0.pop_front();
            chk("resp0_msg", resp0_msg, e);
            chk("resp0_owner", {63'b0, owner}, 64'd0);
          end
        end
        if (resp1_val && resp1_rdy) begin
          if (e1.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL resp1_unexpected: got 0x%0h, expected no response", resp1_msg);
          end else begin
            e = e1.pop_front();
            chk("resp1_msg", resp1_msg, e);
            chk("resp1_owner", {63'b0, owner}, 64'd1);
          end
        end
        if (busy) begin
          chk("busy_req_side", {61'b0, req0_rdy, req1_rdy, mul_req_val}, 64'd0);
          if (owner) begin
            chk("nonowner0", {31'b0, resp0_val, resp0_msg}, 64'd0);
            chk("mul_resp_rdy1", {63'b0, mul_resp_rdy}, {63'b0, resp1_rdy});
          end else begin
            chk("nonowner1", {31'b0, resp1_val, resp1_msg}, 64'd0);
            chk("mul_resp_rdy0", {63'b0, mul_resp_rdy}, {63'b0, resp0_rdy});
          end
        end else begin
          chk("idle_resp_side", {61'b0, resp0_val, resp1_val, mul_resp_rdy}, 64'd0);
          if (!req0_val && !req1_val) chk("idle_nogrant_msg", mul_req_msg, 64'd0);
        end
      end
    end
  end

  initial begin : stimulus
    reset     = 1'b1;
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    mrdy_en   = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_handshakes", {58'b0, req0_rdy, req1_rdy, mul_req_val, mul_resp_rdy,
                           resp0_val, resp1_val}, 64'd0);

    // Contention from reset: both requesters valid while reset is still held.
    tick();
    issue(0, 5, 6, 30);
    issue(1, 7, 8, 56);
    tick();
    @(negedge clk);
    chk("rst_hold_rdy", {61'b0, req0_rdy, req1_rdy, mul_req_val}, 64'd0);
    chk("rst_hold_val_in", {62'b0, req0_val, req1_val}, 64'd3);
    tick();
    reset = 1'b0;
    wait_for(2, "drain_contention");

    // Sustained contention: grants must alternate 0,1,0,1,...
    tick();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    issue(1, 7, 9, 63);
    issue(0, 1000, 1000, 1000000);
    issue(1, 32'h8000_0000, 3, 32'h8000_0000);
    issue(0, 0, 123, 0);
    issue(1, 100, 200, 20000);
    issue(0, 32'h0001_0000, 32'h0001_0000, 0);
    issue(1, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
    wait_for(2, "drain_sustained");

    // Single requester 0: pointer then moves to 1.
    tick();
    issue(0, 3, 4, 12);
    wait_for(2, "drain_single0");
    tick();
    issue(1, 10, 11, 110);
    issue(0, 12, 13, 156);
    wait_for(2, "drain_prio1");

    // Multiplier backpressure on a lone req1.
    tick();
    mrdy_en = 1'b0;
    issue(1, 9, 9, 81);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mbp_req1_rdy", {63'b0, req1_rdy}, 64'd0);
      chk("mbp_idle", {62'b0, busy, mul_req_val}, 64'd1);
      tick();
    end
    mrdy_en = 1'b1;
    @(negedge clk);
    chk("mbp_release_rdy", {63'b0, req1_rdy}, 64'd1);
    wait_for(2, "drain_mbp");

    // Response backpressure from owner 1 with req0 waiting.
    tick();
    resp1_rdy = 1'b0;
    issue(1, 6, 7, 42);
    wait_for(0, "rbp_busy");
    tick();
    issue(0, 2, 3, 6);
    wait_for(1, "rbp_resp_val");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rbp_stall", {60'b0, mul_resp_rdy, req0_rdy, resp1_val, owner}, 64'h3);
    end
    tick();
    resp1_rdy = 1'b1;
    wait_for(2, "drain_rbp");

    // Reset in the middle of an owner-1 transaction.
    tick();
    issue(1, 4, 5, 20);
    wait_for(0, "rst_mid_busy");
    tick();
    reset = 1'b1;
    e1.delete();
    tick();
    @(negedge clk);
    chk("rst_mid_state", {61'b0, busy, resp1_val, mul_req_val}, 64'd0);
    tick();
    reset = 1'b0;
    issue(1, 2, 9, 18);
    wait_for(2, "drain_after_reset");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 400000");
    $fatal(1);
  end

endmodule

// File: doc/lab1_imul_mul_arbiter.md
Name: lab1_imul_mul_arbiter

Overview:
- Shares one iterative, non-pipelined integer multiplier between two independent requesters.
- Each requester has its own val/rdy request and response interfaces.
- Arbitrates with round-robin priority and forwards the winning operands to the multiplier.
- Tracks the single outstanding transaction and steers the result back to its owner.
- Sits between two client blocks and one lab1_imul multiplier instance (fixed- or variable-latency).

Parameters:
- p_nbits, 32: operand/result width. Request message is 2*p_nbits bits: {a, b}, with a in the upper half.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req0_val  input  1  requester 0 request valid
- req0_rdy  output  1  requester 0 request ready
- req0_msg  input  2*p_nbits  requester 0 operands {a,b}
- req1_val  input  1  requester 1 request valid
- req1_rdy  output  1  requester 1 request ready
- req1_msg  input  2*p_nbits  requester 1 operands {a,b}
- resp0_val  output  1  requester 0 response valid
- resp0_rdy  input  1  requester 0 response ready
- resp0_msg  output  p_nbits  requester 0 product
- resp1_val  output  1  requester 1 response valid
- resp1_rdy  input  1  requester 1 response ready
- resp1_msg  output  p_nbits  requester 1 product
- mul_req_val  output  1  to multiplier request valid
- mul_req_rdy  input  1  from multiplier request ready
- mul_req_msg  output  2*p_nbits  operands forwarded to multiplier
- mul_resp_val  input  1  multiplier response valid
- mul_resp_rdy  output  1  to multiplier response ready
- mul_resp_msg  input  p_nbits  multiplier product
- busy  output  1  a transaction is outstanding
- owner  output  1  requester owning the outstanding transaction; meaningful only when busy=1

Behaviour:
- One clock domain; reset is synchronous and active-high.
- On reset:
  - state=IDLE, priority pointer=0, owner register=0.
  - All val/rdy outputs are 0 in the cycle after reset is sampled high, and stay 0 while reset remains high.
- A transfer fires when val && rdy are both high at a clock edge.

State IDLE:
- grant = priority requester if its val=1, else the other requester if its val=1, else none.
- mul_req_val = val of the granted requester; mul_req_msg = its msg (0 if no grant).
- reqN_rdy = mul_req_rdy && (grant==N); the non-granted requester sees rdy=0.
- mul_resp_rdy=0, resp0_val=resp1_val=0, busy=0.
- On mul_req fire:
  - owner <= grant.
  - priority <= ~grant. The pointer flips even when the granted port was the only one requesting.
  - Next state is BUSY.
- With no fire, state and priority are held.

State BUSY:
- req0_rdy=req1_rdy=0, mul_req_val=0, busy=1.
- resp[owner]_val = mul_resp_val; resp[owner]_msg = mul_resp_msg.
- The non-owner response has val=0 and msg=0.
- mul_resp_rdy = resp[owner]_rdy.
- On mul_resp fire, next state is IDLE.
- Response backpressure from the owner stalls the multiplier; nothing is dropped.

Latency and throughput:
- Zero added cycles: all request and response paths are combinational through the FSM-selected muxes.
- At most one transaction in flight.
- After a response fires, a new request can fire at the earliest on the next edge; there is one IDLE cycle between transactions.

Rules:
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Requester msg is only sampled by the multiplier on fire; a requester may change msg while its rdy=0.
- A multiplier response arriving in IDLE is not accepted (mul_resp_rdy=0). This is a protocol error; assert in simulation.
- Reset mid-transaction returns to IDLE and priority 0 with no response issued. The multiplier shares this reset, so its in-flight operation is also discarded.
- Arithmetic is not performed here; the product is the low p_nbits bits as produced by the multiplier.

Test Plan:
- Single requester: req0 {a=3,b=4} with req1 idle -> mul_req_msg={3,4}; resp0_msg=12; resp1_val never asserted; priority becomes 1.
- Contention: both valid from reset, req0 {5,6} and req1 {7,8} -> req0 is granted first (resp0=30), then req1 (resp1=56); grant order 0,1.
- Sustained contention: 4 transactions per port, all valid -> grant order strictly 0,1,0,1,0,1,0,1; every product is correct, including 0xFFFFFFFF*0xFFFFFFFF -> resp msg 1.
- Response backpressure: owner=1 holds resp1_rdy=0 for 5 cycles while mul_resp_val=1 -> mul_resp_rdy=0 and req0_rdy=0 throughout; resp1 fires with the correct value once resp1_rdy=1.
- Multiplier backpressure: mul_req_rdy=0 for 3 cycles with req1 valid -> req1_rdy=0 and state stays IDLE; req1 fires in the cycle mul_req_rdy rises.
- Reset mid-op: reset asserted while BUSY with owner=1 -> next cycle busy=0, resp1_val=0, priority=0; a subsequent req1 {2,9} returns 18.
